// File: rtl/serial_pkg.sv
// Shared definitions for the serial boot path: loader and strobe state
// encodings, frame constants and the serial port controller mode codes.
package serial_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LEN_LO   = 4'd1,
    ST_LEN_HI   = 4'd2,
    ST_DATA_LO  = 4'd3,
    ST_DATA_HI  = 4'd4,
    ST_WR_SETUP = 4'd5,
    ST_WR_PULSE = 4'd6,
    ST_WR_HOLD  = 4'd7,
    ST_CSUM     = 4'd8,
    ST_DONE     = 4'd9
  } load_state_t;

  typedef enum logic [1:0] {
    WS_IDLE  = 2'd0,
    WS_SETUP = 2'd1,
    WS_PULSE = 2'd2,
    WS_HOLD  = 2'd3
  } strobe_phase_t;

  localparam int LEN_BYTES  = 2;
  localparam int CSUM_BYTES = 1;

  // Operating modes shared with the serial port controller.
  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_RX   = 2'd1;
  localparam logic [1:0] MODE_TX   = 2'd2;
  localparam logic [1:0] MODE_LOOP = 2'd3;

  // States in which the loader is willing to take a byte from the UART.
  function automatic logic rx_state(input load_state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA_LO) ||
           (s == ST_DATA_HI) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/serial_loader_if.sv
// Byte stream from the serial port controller plus the RAM2 write bus.
interface serial_loader_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_data;
  logic                  ram_wen;
  logic                  ram_en;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, ram_addr, ram_data, ram_wen, ram_en
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, ram_addr, ram_data, ram_wen, ram_en
  );
endinterface

// File: rtl/serial_loader_strobe.sv
// RAM2 write sequencer: setup, one-cycle active-low write pulse, hold.
// Address tracks its input while idle; address and data are frozen once go is seen.
module ram2_write_strobe
  import serial_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_data,
  output logic                  ram_en,
  output logic                  ram_wen,
  output logic                  finished
);

  strobe_phase_t phase, phase_nxt;

  // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      WS_IDLE:  if (go) phase_nxt = WS_SETUP;
      WS_SETUP: phase_nxt = WS_PULSE;
      WS_PULSE: phase_nxt = WS_HOLD;
      WS_HOLD:  phase_nxt = WS_IDLE;
      default:  phase_nxt = WS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase    <= WS_IDLE;
      ram_en   <= 1'b1;
      ram_wen  <= 1'b1;
      ram_addr <= RESET_ADDR;
      ram_data <= '0;
    end else begin
      phase   <= phase_nxt;
      // Strobes are registered from the next phase so the RAM pins never glitch.
      ram_en  <= (phase_nxt == WS_IDLE);
      ram_wen <= (phase_nxt != WS_PULSE);
      if (phase == WS_IDLE) begin
        ram_addr <= addr;
        if (go) ram_data <= data;
      end
    end
  end

  assign finished = (phase == WS_HOLD);

endmodule

// File: rtl/serial_loader.sv
// Loads a length-prefixed, XOR-checksummed program image from the UART byte
// stream into RAM2 and reports done/length/checksum status to boot control.
module serial_loader
  import serial_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [15:0]           MAX_WORDS  = 16'h8000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  serial_loader_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            len_error,
  output logic            csum_ok,
  output logic [15:0]     words_loaded
);

  load_state_t           state, state_nxt;
  logic                  rx_ready_q;
  logic [15:0]           len_q;
  logic [7:0]            data_lo_q;
  logic [7:0]            acc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           words_q;
  logic                  len_error_q;
  logic                  csum_ok_q;

  logic        accept;
  logic [15:0] n_word;
  logic        go;
  logic        wr_finished;
  logic        last_word;

  assign accept    = bus.rx_valid && rx_ready_q;
  assign n_word    = {bus.rx_data, len_q[7:0]};
  assign go        = (state == ST_DATA_HI) && accept;
  assign last_word = ((words_q + 16'd1) == len_q);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_LEN_LO;
      ST_LEN_LO:        if (accept) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (n_word == 16'd0)        state_nxt = ST_CSUM;
          else if (n_word > MAX_WORDS) state_nxt = ST_DONE;
          else                         state_nxt = ST_DATA_LO;
        end
      end
      ST_DATA_LO:  if (accept) state_nxt = ST_DATA_HI;
      ST_DATA_HI:  if (accept) state_nxt = ST_WR_SETUP;
      ST_WR_SETUP: state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:  if (wr_finished) state_nxt = last_word ? ST_CSUM : ST_DATA_LO;
      ST_CSUM:     if (accept) state_nxt = ST_DONE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_ready_q  <= 1'b0;
      len_q       <= '0;
      data_lo_q   <= '0;
      acc_q       <= '0;
      addr_q      <= BASE_ADDR;
      words_q     <= '0;
      len_error_q <= 1'b0;
      csum_ok_q   <= 1'b0;
    end else begin
      rx_ready_q <= rx_state(state_nxt);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_q       <= '0;
            acc_q       <= '0;
            addr_q      <= BASE_ADDR;
            words_q     <= '0;
            len_error_q <= 1'b0;
            csum_ok_q   <= 1'b0;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= bus.rx_data;
            acc_q      <= acc_q ^ bus.rx_data;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_q[15:8] <= bus.rx_data;
            acc_q       <= acc_q ^ bus.rx_data;
            if (n_word > MAX_WORDS) len_error_q <= 1'b1;
          end
        end
        ST_DATA_LO: begin
          if (accept) begin
            data_lo_q <= bus.rx_data;
            acc_q     <= acc_q ^ bus.rx_data;
          end
        end
        ST_DATA_HI: if (accept) acc_q <= acc_q ^ bus.rx_data;
        ST_WR_HOLD: begin
          // Address wraps naturally at 2^ADDR_WIDTH.
          if (wr_finished) begin
            words_q <= words_q + 16'd1;
            addr_q  <= addr_q + 1'b1;
          end
        end
        ST_CSUM: if (accept) csum_ok_q <= (bus.rx_data == acc_q);
        default: ;
      endcase
    end
  end

  ram2_write_strobe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_ADDR (BASE_ADDR)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .addr     (addr_q),
    .data     ({bus.rx_data, data_lo_q}),
    .ram_addr (bus.ram_addr),
    .ram_data (bus.ram_data),
    .ram_en   (bus.ram_en),
    .ram_wen  (bus.ram_wen),
    .finished (wr_finished)
  );

  assign bus.rx_ready  = rx_ready_q;
  assign busy          = (state != ST_IDLE) && (state != ST_DONE);
  assign done          = (state == ST_DONE);
  assign len_error     = len_error_q;
  assign csum_ok       = csum_ok_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_serial_loader.sv
// Bench for serial_loader: two instances (default and small-limit/top-of-memory
// base), UART byte driver, RAM2 write monitor and a write scoreboard.
module tb_serial_loader;

  localparam int AW = 18;
  localparam logic [AW-1:0] BASE_A = '0;
  localparam logic [AW-1:0] BASE_B = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start    = 1'b0;
  logic       sel      = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;

  serial_loader_if #(.ADDR_WIDTH(AW)) if_a ();
  serial_loader_if #(.ADDR_WIDTH(AW)) if_b ();

  assign if_a.rx_valid = rx_valid & ~sel;
  assign if_a.rx_data  = rx_data;
  assign if_b.rx_valid = rx_valid & sel;
  assign if_b.rx_data  = rx_data;

  logic        busy_a, done_a, lerr_a, cok_a, busy_b, done_b, lerr_b, cok_b;
  logic [15:0] wl_a, wl_b;

  serial_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE_A), .MAX_WORDS(16'h8000)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .bus(if_a.master), .busy(busy_a),
    .done(done_a), .len_error(lerr_a), .csum_ok(cok_a), .words_loaded(wl_a));

  serial_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE_B), .MAX_WORDS(16'd4)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .bus(if_b.master), .busy(busy_b),
    .done(done_b), .len_error(lerr_b), .csum_ok(cok_b), .words_loaded(wl_b));

  wire          cur_ready = sel ? if_b.rx_ready : if_a.rx_ready;
  wire          cur_wen   = sel ? if_b.ram_wen  : if_a.ram_wen;
  wire          cur_en    = sel ? if_b.ram_en   : if_a.ram_en;
  wire [AW-1:0] cur_addr  = sel ? if_b.ram_addr : if_a.ram_addr;
  wire [15:0]   cur_data  = sel ? if_b.ram_data : if_a.ram_data;
  wire          cur_busy  = sel ? busy_b : busy_a;
  wire          cur_done  = sel ? done_b : done_a;
  wire          cur_lerr  = sel ? lerr_b : lerr_a;
  wire          cur_cok   = sel ? cok_b  : cok_a;
  wire [15:0]   cur_words = sel ? wl_b   : wl_a;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         exp_w;
  logic [15:0] ram_model [logic [AW-1:0]];
  logic [15:0] frame_words[$];
  int          errors = 0;
  int          checks = 0;
  int          wen_lows = 0;
  int          busy_cycles = 0;
  logic        prev_wen_low = 1'b0;

  function automatic logic [15:0] read_ram(input logic [AW-1:0] a);
    return ram_model.exists(a) ? ram_model[a] : 16'hxxxx;
  endfunction

  // RAM2 monitor: every write pulse is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      prev_wen_low = 1'b0;
    end else begin
      if (cur_busy) busy_cycles++;
      if (!cur_wen) begin
        wen_lows++;
        checks++;
        if (cur_en !== 1'b0 || prev_wen_low) begin
          errors++;
          $display("FAIL wen_shape: en=%b prev_wen_low=%b, want en=0 and single-cycle pulse", cur_en, prev_wen_low);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h with empty scoreboard", cur_addr, cur_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (cur_addr !== exp_w.addr || cur_data !== exp_w.data) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h want addr=%h data=%h",
                     cur_addr, cur_data, exp_w.addr, exp_w.data);
          end
        end
        ram_model[cur_addr] = cur_data;
      end
      prev_wen_low = !cur_wen;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int budget;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 0;
    @(negedge clk);
    while (!cur_ready && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (!cur_ready) begin
      errors++;
      $display("FAIL send_byte: byte %h never accepted, rx_ready=%b want 1", b, cur_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    @(negedge clk);
    while (!cur_done && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    checks++;
    if (!cur_done) begin
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, want 1", cur_done, budget);
    end
  endtask

  // Drives one frame from frame_words, pushing expected writes as words are sent.
  task automatic load_frame(input logic [15:0] n, input logic [7:0] csum_xor,
                            input int gap, input bit mid_start);
    logic [7:0]    acc;
    logic [AW-1:0] a;
    logic [AW-1:0] base;
    logic [15:0]   w;
    base = sel ? BASE_B : BASE_A;
    acc  = n[7:0] ^ n[15:8];
    pulse_start();
    checks++;
    if (cur_done !== 1'b0 || cur_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_arm: done=%b busy=%b want done=0 busy=1", cur_done, cur_busy);
    end
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    if (mid_start) begin
      pulse_start();
      checks++;
      if (cur_busy !== 1'b1) begin
        errors++;
        $display("FAIL start_busy: busy=%b want 1", cur_busy);
      end
    end
    for (int i = 0; i < int'(n); i++) begin
      w = frame_words[i];
      a = base + i[AW-1:0];
      exp_q.push_back('{addr: a, data: w});
      acc = acc ^ w[7:0] ^ w[15:8];
      send_byte(w[7:0], gap);
      send_byte(w[15:8], gap);
    end
    send_byte(acc ^ csum_xor, gap);
    wait_done();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if_a.rx_ready !== 1'b0 || if_a.ram_wen !== 1'b1 || if_a.ram_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_pins: ready=%b wen=%b en=%b want 0 1 1", if_a.rx_ready, if_a.ram_wen, if_a.ram_en);
    end
    checks++;
    if (if_a.ram_addr !== BASE_A || if_a.ram_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h want %h 0000", if_a.ram_addr, if_a.ram_data, BASE_A);
    end
    checks++;
    if (if_b.ram_addr !== BASE_B) begin
      errors++;
      $display("FAIL reset_base_b: addr=%h want %h", if_b.ram_addr, BASE_B);
    end
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || lerr_a !== 1'b0 || cok_a !== 1'b0 || wl_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b lerr=%b cok=%b words=%0d want all 0",
               busy_a, done_a, lerr_a, cok_a, wl_a);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic check_status(input string tag, input logic exp_cok, input logic exp_lerr,
                              input logic [15:0] exp_words, input int exp_wen);
    checks++;
    if (cur_done !== 1'b1 || cur_cok !== exp_cok || cur_lerr !== exp_lerr || cur_words !== exp_words) begin
      errors++;
      $display("FAIL %s_status: done=%b cok=%b lerr=%b words=%0d want 1 %b %b %0d",
               tag, cur_done, cur_cok, cur_lerr, cur_words, exp_cok, exp_lerr, exp_words);
    end
    checks++;
    if (wen_lows !== exp_wen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: wen_lows=%0d pending=%0d want %0d 0", tag, wen_lows, exp_q.size(), exp_wen);
    end
  endtask

  task automatic test_basic_load();
    sel = 1'b0; wen_lows = 0; ram_model.delete();
    frame_words = '{16'h1234, 16'hABCD};
    load_frame(16'd2, 8'h00, 0, 1'b0);
    check_status("basic", 1'b1, 1'b0, 16'd2, 2);
    checks++;
    if (read_ram(18'd0) !== 16'h1234 || read_ram(18'd1) !== 16'hABCD) begin
      errors++;
      $display("FAIL basic_ram: ram0=%h ram1=%h want 1234 abcd", read_ram(18'd0), read_ram(18'd1));
    end
  endtask

  task automatic test_bad_csum();
    sel = 1'b0; wen_lows = 0; ram_model.delete();
    frame_words = '{16'h1234, 16'hABCD};
    load_frame(16'd2, 8'h01, 0, 1'b0);
    check_status("bad_csum", 1'b0, 1'b0, 16'd2, 2);
  endtask

  task automatic test_zero_len();
    sel = 1'b0; wen_lows = 0;
    frame_words.delete();
    load_frame(16'd0, 8'h00, 0, 1'b0);
    check_status("zero_len", 1'b1, 1'b0, 16'd0, 0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; wen_lows = 0;
    frame_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    busy_cycles = 0;
    load_frame(16'd4, 8'h00, 0, 1'b0);
    check_status("b2b", 1'b1, 1'b0, 16'd4, 4);
    // Two length bytes, five cycles per word, one checksum byte.
    checks++;
    if (busy_cycles !== 2 + 5 * 4 + 1) begin
      errors++;
      $display("FAIL b2b_latency: busy_cycles=%0d want %0d", busy_cycles, 2 + 5 * 4 + 1);
    end
  endtask

  task automatic test_start_while_busy();
    sel = 1'b0; wen_lows = 0; ram_model.delete();
    frame_words = '{16'h5A5A, 16'h0F0F};
    load_frame(16'd2, 8'h00, 0, 1'b1);
    check_status("start_busy", 1'b1, 1'b0, 16'd2, 2);
    checks++;
    if (read_ram(18'd0) !== 16'h5A5A || read_ram(18'd1) !== 16'h0F0F) begin
      errors++;
      $display("FAIL start_busy_ram: ram0=%h ram1=%h want 5a5a 0f0f", read_ram(18'd0), read_ram(18'd1));
    end
  endtask

  task automatic test_len_overflow();
    int grabbed = 0;
    sel = 1'b1; wen_lows = 0;
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    wait_done();
    check_status("overflow", 1'b0, 1'b1, 16'd0, 0);
    rx_data = 8'h55; rx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (cur_ready) grabbed++;
    end
    rx_valid = 1'b0;
    checks++;
    if (grabbed != 0 || cur_done !== 1'b1) begin
      errors++;
      $display("FAIL overflow_hold: ready cycles=%0d done=%b want 0 1", grabbed, cur_done);
    end
  endtask

  task automatic test_wrap_handshake();
    sel = 1'b1; wen_lows = 0; ram_model.delete();
    frame_words = '{16'($urandom), 16'($urandom)};
    load_frame(16'd2, 8'h00, 3, 1'b0);
    check_status("wrap", 1'b1, 1'b0, 16'd2, 2);
    checks++;
    if (read_ram(BASE_B) !== frame_words[0] || read_ram('0) !== frame_words[1]) begin
      errors++;
      $display("FAIL wrap_ram: top=%h zero=%h want %h %h",
               read_ram(BASE_B), read_ram('0), frame_words[0], frame_words[1]);
    end
  endtask

  task automatic test_reset_mid_write();
    int budget = 0;
    logic [15:0] w;
    sel = 1'b0; wen_lows = 0;
    w = 16'hBEEF;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    exp_q.push_back('{addr: BASE_A, data: w});
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    @(negedge clk);
    while (cur_wen && budget < 10) begin
      budget++;
      @(negedge clk);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cur_wen !== 1'b1 || cur_en !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: wen=%b en=%b busy=%b done=%b ready=%b want 1 1 0 0 0",
               cur_wen, cur_en, cur_busy, cur_done, cur_ready);
    end
    checks++;
    if (wen_lows != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: wen_lows=%0d pending=%0d want 1 0", wen_lows, exp_q.size());
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_csum();
    test_zero_len();
    test_back_to_back();
    test_start_while_busy();
    test_len_overflow();
    test_wrap_handshake();
    test_reset_mid_write();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
